// File: rtl/darkbus_arbiter.sv
// Two-master, one-slave bus arbiter: grants one whole transaction at a time, registers the
// response to the owning master and aborts a hung slave with an error after TIMEOUT cycles.
module darkbus_arbiter #(
    parameter int unsigned PRIORITY = 0,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk_i,
    input  logic        res_i,

    input  logic        m0_en_i,
    input  logic        m0_rw_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic [31:0] m0_rdata_o,
    output logic        m0_valid_o,
    output logic        m0_err_o,

    input  logic        m1_en_i,
    input  logic        m1_rw_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic [31:0] m1_rdata_o,
    output logic        m1_valid_o,
    output logic        m1_err_o,

    output logic        s_en_o,
    output logic        s_rw_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_wdata_o,
    input  logic [31:0] s_rdata_i,
    input  logic        s_valid_i,

    output logic        owner_o,
    output logic        busy_o
);

    localparam int unsigned CntW = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e          state_q;
    logic            owner_q;
    logic            last_q;
    logic [CntW-1:0] cnt_q;
    logic            s_en_q;
    logic            s_rw_q;
    logic [31:0]     s_addr_q;
    logic [31:0]     s_wdata_q;
    logic [31:0]     m0_rdata_q;
    logic            m0_valid_q;
    logic            m0_err_q;
    logic [31:0]     m1_rdata_q;
    logic            m1_valid_q;
    logic            m1_err_q;

    logic        elig0;
    logic        elig1;
    logic        grant;
    logic        grant_id;
    logic        sel_rw;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        timeout_hit;

    // A master's request is ignored during its own completion pulse so it can drop en there.
    always_comb begin
        elig0 = m0_en_i & ~m0_valid_q;
        elig1 = m1_en_i & ~m1_valid_q;
        grant = elig0 | elig1;
        if (elig0 && elig1) begin
            grant_id = (PRIORITY == 1) ? 1'b1 : ~last_q;
        end else begin
            grant_id = elig1;
        end
        sel_rw      = grant_id ? m1_rw_i    : m0_rw_i;
        sel_addr    = grant_id ? m1_addr_i  : m0_addr_i;
        sel_wdata   = grant_id ? m1_wdata_i : m0_wdata_i;
        timeout_hit = (TIMEOUT != 0) && (cnt_q == CntLast);
    end

    always_ff @(posedge clk_i or posedge res_i) begin
        if (res_i) begin
            state_q    <= StIdle;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            cnt_q      <= '0;
            s_en_q     <= 1'b0;
            s_rw_q     <= 1'b0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            m0_rdata_q <= '0;
            m0_valid_q <= 1'b0;
            m0_err_q   <= 1'b0;
            m1_rdata_q <= '0;
            m1_valid_q <= 1'b0;
            m1_err_q   <= 1'b0;
        end else begin
            m0_valid_q <= 1'b0;
            m0_err_q   <= 1'b0;
            m1_valid_q <= 1'b0;
            m1_err_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (grant) begin
                        state_q   <= StBusy;
                        owner_q   <= grant_id;
                        last_q    <= grant_id;
                        s_en_q    <= 1'b1;
                        s_rw_q    <= sel_rw;
                        s_addr_q  <= sel_addr;
                        s_wdata_q <= sel_wdata;
                        cnt_q     <= '0;
                    end
                end
                StBusy: begin
                    if (s_valid_i || timeout_hit) begin
                        // A real response beats a timeout expiring in the same cycle.
                        state_q <= StIdle;
                        s_en_q  <= 1'b0;
                        if (owner_q) begin
                            m1_valid_q <= 1'b1;
                            m1_err_q   <= ~s_valid_i;
                            m1_rdata_q <= s_valid_i ? s_rdata_i : 32'h0;
                        end else begin
                            m0_valid_q <= 1'b1;
                            m0_err_q   <= ~s_valid_i;
                            m0_rdata_q <= s_valid_i ? s_rdata_i : 32'h0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign s_en_o     = s_en_q;
    assign s_rw_o     = s_rw_q;
    assign s_addr_o   = s_addr_q;
    assign s_wdata_o  = s_wdata_q;
    assign m0_rdata_o = m0_rdata_q;
    assign m0_valid_o = m0_valid_q;
    assign m0_err_o   = m0_err_q;
    assign m1_rdata_o = m1_rdata_q;
    assign m1_valid_o = m1_valid_q;
    assign m1_err_o   = m1_err_q;
    assign owner_o    = owner_q;
    assign busy_o     = (state_q == StBusy);

endmodule

// File: tb/tb_darkbus_arbiter.sv
// Directed bench: a round-robin arbiter with TIMEOUT=4 and a fixed-priority arbiter with the
// timeout disabled share one set of inputs, so their differing responses can be compared.
module tb_darkbus_arbiter;

    logic        clk_i = 1'b0;
    logic        res_i;
    logic        m0_en_i, m0_rw_i, m1_en_i, m1_rw_i, s_valid_i;
    logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i, s_rdata_i;

    logic [31:0] a_m0_rdata, a_m1_rdata, a_s_addr, a_s_wdata;
    logic        a_m0_valid, a_m0_err, a_m1_valid, a_m1_err, a_s_en, a_s_rw, a_owner, a_busy;
    logic [31:0] f_m0_rdata, f_m1_rdata, f_s_addr, f_s_wdata;
    logic        f_m0_valid, f_m0_err, f_m1_valid, f_m1_err, f_s_en, f_s_rw, f_owner, f_busy;

    int tests_run = 0;
    int failures  = 0;

    always #5 clk_i = ~clk_i;

    darkbus_arbiter #(.PRIORITY(0), .TIMEOUT(4)) u_dut_rr (
        .clk_i(clk_i), .res_i(res_i),
        .m0_en_i(m0_en_i), .m0_rw_i(m0_rw_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
        .m0_rdata_o(a_m0_rdata), .m0_valid_o(a_m0_valid), .m0_err_o(a_m0_err),
        .m1_en_i(m1_en_i), .m1_rw_i(m1_rw_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
        .m1_rdata_o(a_m1_rdata), .m1_valid_o(a_m1_valid), .m1_err_o(a_m1_err),
        .s_en_o(a_s_en), .s_rw_o(a_s_rw), .s_addr_o(a_s_addr), .s_wdata_o(a_s_wdata),
        .s_rdata_i(s_rdata_i), .s_valid_i(s_valid_i), .owner_o(a_owner), .busy_o(a_busy)
    );

    darkbus_arbiter #(.PRIORITY(1), .TIMEOUT(0)) u_dut_fp (
        .clk_i(clk_i), .res_i(res_i),
        .m0_en_i(m0_en_i), .m0_rw_i(m0_rw_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
        .m0_rdata_o(f_m0_rdata), .m0_valid_o(f_m0_valid), .m0_err_o(f_m0_err),
        .m1_en_i(m1_en_i), .m1_rw_i(m1_rw_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
        .m1_rdata_o(f_m1_rdata), .m1_valid_o(f_m1_valid), .m1_err_o(f_m1_err),
        .s_en_o(f_s_en), .s_rw_o(f_s_rw), .s_addr_o(f_s_addr), .s_wdata_o(f_s_wdata),
        .s_rdata_i(s_rdata_i), .s_valid_i(s_valid_i), .owner_o(f_owner), .busy_o(f_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        m0_en_i = 0; m0_rw_i = 0; m0_addr_i = '0; m0_wdata_i = '0;
        m1_en_i = 0; m1_rw_i = 0; m1_addr_i = '0; m1_wdata_i = '0;
        s_valid_i = 0; s_rdata_i = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        @(posedge clk_i);
        #1 res_i = 1;
        @(posedge clk_i);
        #1 res_i = 0;
    endtask

    initial begin
        res_i = 1;
        clear_inputs();
        @(posedge clk_i);
        #2;
        check("rst_s_en", 32'(a_s_en), 0);
        check("rst_busy", 32'(a_busy), 0);
        check("rst_owner", 32'(a_owner), 0);
        check("rst_m0_valid", 32'(a_m0_valid), 0);
        check("rst_m1_valid", 32'(a_m1_valid), 0);
        check("rst_m0_rdata", a_m0_rdata, 0);
        check("rst_s_addr", a_s_addr, 0);
        check("rst_s_wdata", a_s_wdata, 0);
        apply_reset();

        // Single read, slave answers in the third s_en cycle.
        m0_en_i = 1; m0_rw_i = 0; m0_addr_i = 32'h100;
        tick();
        check("rd_s_en", 32'(a_s_en), 1);
        check("rd_s_addr", a_s_addr, 32'h100);
        check("rd_s_rw", 32'(a_s_rw), 0);
        check("rd_owner", 32'(a_owner), 0);
        tick();
        tick();
        check("rd_no_early_valid", 32'(a_m0_valid), 0);
        s_valid_i = 1; s_rdata_i = 32'hDEADBEEF;
        tick();
        check("rd_m0_valid", 32'(a_m0_valid), 1);
        check("rd_m0_rdata", a_m0_rdata, 32'hDEADBEEF);
        check("rd_m0_err", 32'(a_m0_err), 0);
        check("rd_m1_valid", 32'(a_m1_valid), 0);
        check("rd_idle", 32'(a_busy), 0);
        m0_en_i = 0; s_valid_i = 0; s_rdata_i = '0;
        tick();
        check("rd_valid_pulse", 32'(a_m0_valid), 0);
        check("rd_rdata_hold", a_m0_rdata, 32'hDEADBEEF);

        // Contention with both continuously requesting and the slave always ready.
        apply_reset();
        m0_en_i = 1; m1_en_i = 1; s_valid_i = 1; s_rdata_i = 32'hA5A50000;
        tick();
        check("fp_first_grant", 32'(f_owner), 1);
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                tick();
                tick();
            end
            check("rr_owner", 32'(a_owner), (i % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_busy", 32'(a_busy), 1);
        end
        tick();
        check("rr_m0_valid_last", 32'(a_m0_valid), 1);
        check("rr_m1_quiet", 32'(a_m1_valid), 0);
        clear_inputs();
        tick();

        // Simultaneous request after a master-1 grant: round-robin picks 0, fixed picks 1.
        apply_reset();
        m1_en_i = 1; s_valid_i = 1;
        tick();
        tick();
        m1_en_i = 0;
        tick();
        m0_en_i = 1; m1_en_i = 1;
        tick();
        check("tie_rr_owner", 32'(a_owner), 0);
        check("tie_fp_owner", 32'(f_owner), 1);
        clear_inputs();
        tick();
        tick();

        // Write passthrough; master inputs change mid-transaction.
        apply_reset();
        m1_en_i = 1; m1_rw_i = 1; m1_addr_i = 32'h2004; m1_wdata_i = 32'h12345678;
        tick();
        check("wr_owner", 32'(a_owner), 1);
        m1_rw_i = 0; m1_addr_i = 32'hFFFF0000; m1_wdata_i = 32'h0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("wr_s_rw", 32'(a_s_rw), 1);
            check("wr_s_addr", a_s_addr, 32'h2004);
            check("wr_s_wdata", a_s_wdata, 32'h12345678);
        end
        s_valid_i = 1; s_rdata_i = 32'h0BADF00D;
        tick();
        check("wr_m1_valid", 32'(a_m1_valid), 1);
        check("wr_m1_rdata", a_m1_rdata, 32'h0BADF00D);
        check("wr_m0_valid", 32'(a_m0_valid), 0);
        check("wr_s_en_drop", 32'(a_s_en), 0);
        clear_inputs();
        tick();
        check("wr_single_pulse", 32'(a_m1_valid), 0);

        // s_valid in the fourth busy cycle coincides with the timeout; data must win.
        apply_reset();
        m0_en_i = 1; m0_addr_i = 32'h44;
        tick();
        tick();
        tick();
        tick();
        s_valid_i = 1; s_rdata_i = 32'hCAFE0004;
        tick();
        check("race_valid", 32'(a_m0_valid), 1);
        check("race_err", 32'(a_m0_err), 0);
        check("race_rdata", a_m0_rdata, 32'hCAFE0004);
        clear_inputs();
        tick();

        // Timeout: slave silent, abort four cycles after s_en rises.
        m0_en_i = 1; m0_addr_i = 32'h48;
        tick();
        check("to_s_en", 32'(a_s_en), 1);
        tick();
        tick();
        tick();
        check("to_not_yet", 32'(a_m0_valid), 0);
        tick();
        check("to_valid", 32'(a_m0_valid), 1);
        check("to_err", 32'(a_m0_err), 1);
        check("to_rdata", a_m0_rdata, 0);
        check("to_s_en_drop", 32'(a_s_en), 0);
        check("to_disabled_busy", 32'(f_busy), 1);
        check("to_disabled_valid", 32'(f_m0_valid), 0);
        m0_en_i = 0; s_valid_i = 1; s_rdata_i = 32'h5;
        tick();
        check("to_disabled_done", 32'(f_m0_valid), 1);
        check("to_disabled_err", 32'(f_m0_err), 0);
        clear_inputs();
        tick();

        // Asynchronous reset mid-transaction, then a fresh request.
        m1_en_i = 1; m1_addr_i = 32'h300;
        tick();
        check("mr_busy_before", 32'(a_s_en), 1);
        #3 res_i = 1;
        #1;
        check("mr_s_en_async", 32'(a_s_en), 0);
        check("mr_busy_async", 32'(a_busy), 0);
        s_valid_i = 1;
        @(posedge clk_i);
        #1;
        check("mr_no_valid", 32'(a_m1_valid), 0);
        res_i = 0; s_valid_i = 0;
        tick();
        check("mr_regrant_owner", 32'(a_owner), 1);
        check("mr_regrant_addr", a_s_addr, 32'h300);
        check("mr_no_valid_after", 32'(a_m1_valid), 0);
        s_valid_i = 1; s_rdata_i = 32'h77;
        tick();
        check("mr_served", 32'(a_m1_valid), 1);
        check("mr_rdata", a_m1_rdata, 32'h77);
        clear_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
